// File: rtl/decoder_10b8b_pkg.sv
// decoder_10b8b_pkg: shared 8b/10b constants for encoder and decoder.
// Sub-block widths, lock FSM states and both RD columns of 6b/4b codes.
package decoder_10b8b_pkg;

  localparam int W6 = 6;
  localparam int W4 = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_st_e;

  // Index = 5b value (byte bits [4:0]); code is abcdei, a in bit 5.
  localparam logic [5:0] C6_RD0 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  localparam logic [5:0] C6_RD1 [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001,
    6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001,
    6'b001110, 6'b010001, 6'b100001, 6'b010100
  };

  // Index = 3b value (byte bits [7:5]); code is fghj, f in bit 3.
  localparam logic [3:0] C4_RD0 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  localparam logic [3:0] C4_RD1 [8] = '{
    4'b0100, 4'b1001, 4'b0101, 4'b0011,
    4'b0010, 4'b1010, 4'b0110, 4'b0001
  };

  // Table entry, zero-extended to 6 bits for the 4b tables.
  function automatic logic [5:0] code_ent(
    input bit         is6,
    input logic       rd,
    input logic [4:0] idx
  );
    logic [5:0] e;
    if (is6)
      e = rd ? C6_RD1[idx] : C6_RD0[idx];
    else
      e = {2'b00, rd ? C4_RD1[idx[2:0]] : C4_RD0[idx[2:0]]};
    return e;
  endfunction

endpackage

// File: rtl/decoder_10b8b_if.sv
// decoder_10b8b_if: code-word in / byte-and-status out bundle.
// master = upstream + byte sink side, slave = decoder.
interface decoder_10b8b_if;
  logic        in_valid;
  logic [9:0]  data_in;
  logic        err_clr;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        code_err;
  logic        disp_err;
  logic        rd;
  logic        locked;
  logic [15:0] err_count;

  modport master (
    output in_valid, data_in, err_clr,
    input  data_out, out_valid, code_err, disp_err,
    input  rd, locked, err_count
  );

  modport slave (
    input  in_valid, data_in, err_clr,
    output data_out, out_valid, code_err, disp_err,
    output rd, locked, err_count
  );
endinterface

// File: rtl/decoder_10b8b_lut.sv
// dec_subblock_lut: (code, rd) -> value, hit in current / other RD table.
// Ports: code_i, rd_i in; val_o, hit_cur_o, hit_oth_o out (combinational).
module dec_subblock_lut
  import decoder_10b8b_pkg::*;
#(
  parameter  int CW = 6,
  localparam int VW = CW - 1
) (
  input  logic [CW-1:0] code_i,
  input  logic          rd_i,
  output logic [VW-1:0] val_o,
  output logic          hit_cur_o,
  output logic          hit_oth_o
);

  localparam bit IS6 = (CW == W6);
  localparam int N   = 1 << VW;

  logic [5:0] ec;
  logic [5:0] eo;

  // The union of both columns is unambiguous, so either hit
  // yields the same value.
  always_comb begin
    val_o     = '0;
    hit_cur_o = 1'b0;
    hit_oth_o = 1'b0;
    ec        = '0;
    eo        = '0;
    for (int i = 0; i < N; i++) begin
      ec = code_ent(IS6, rd_i, 5'(i));
      eo = code_ent(IS6, ~rd_i, 5'(i));
      if (6'(code_i) == ec) begin
        hit_cur_o = 1'b1;
        val_o     = VW'(i);
      end
      if (6'(code_i) == eo) begin
        hit_oth_o = 1'b1;
        val_o     = VW'(i);
      end
    end
  end

endmodule

// File: rtl/decoder_10b8b.sv
// decoder_10b8b: 10b->8b decode with RD tracking, error flags/count, lock FSM.
// Ports: clk, rst (async, active-low), bus (decoder_10b8b_if.slave).
module decoder_10b8b
  import decoder_10b8b_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  decoder_10b8b_if.slave  bus
);

  logic [4:0]  v6;
  logic [2:0]  v4;
  logic        h6c, h6o, h4c, h4o;
  logic        cerr, derr, werr;
  logic [3:0]  ones;
  logic        rd_d, rd_q;
  logic [15:0] ecnt_d, ecnt_q;
  logic [7:0]  data_q;
  logic        ov_q, ce_q, de_q;
  logic        locked_q;
  lock_st_e    state_q;
  logic [3:0]  good_q, bad_q;
  logic [3:0]  good_nx, bad_nx;

  dec_subblock_lut #(.CW(W6)) u_lut6 (
    .code_i    (bus.data_in[9:4]),
    .rd_i      (rd_q),
    .val_o     (v6),
    .hit_cur_o (h6c),
    .hit_oth_o (h6o)
  );

  dec_subblock_lut #(.CW(W4)) u_lut4 (
    .code_i    (bus.data_in[3:0]),
    .rd_i      (rd_q),
    .val_o     (v4),
    .hit_cur_o (h4c),
    .hit_oth_o (h4o)
  );

  assign cerr = (!h6c && !h6o) || (!h4c && !h4o);
  assign derr = (!h6c && h6o) || (!h4c && h4o);
  assign werr = cerr | derr;
  assign ones = 4'($countones(bus.data_in));

  // Unbalanced words force RD; a neutral word keeps the
  // effective RD (flipped when the word was a disparity error).
  always_comb begin
    rd_d = rd_q ^ derr;
    if (ones > 4'd5)
      rd_d = 1'b1;
    else if (ones < 4'd5)
      rd_d = 1'b0;
  end

  // Clear beats a same-cycle error.
  always_comb begin
    ecnt_d = ecnt_q;
    if (bus.err_clr)
      ecnt_d = '0;
    else if (bus.in_valid && werr && ecnt_q != 16'hFFFF)
      ecnt_d = ecnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      ov_q   <= 1'b0;
      ce_q   <= 1'b0;
      de_q   <= 1'b0;
      rd_q   <= 1'b0;
      ecnt_q <= '0;
    end else begin
      ov_q   <= bus.in_valid;
      ecnt_q <= ecnt_d;
      if (bus.in_valid) begin
        data_q <= {v4, v6};
        ce_q   <= cerr;
        de_q   <= derr;
        rd_q   <= rd_d;
      end
    end
  end

  assign good_nx = good_q + 4'd1;
  assign bad_nx  = bad_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      locked_q <= 1'b0;
      good_q   <= '0;
      bad_q    <= '0;
    end else if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (werr)
            good_q <= '0;
          else if (good_nx == 4'(LOCK_CNT)) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            good_q   <= '0;
          end else
            good_q <= good_nx;
        end
        LOCKED: begin
          if (!werr)
            bad_q <= '0;
          else if (bad_nx == 4'(UNLOCK_CNT)) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            bad_q    <= '0;
          end else
            bad_q <= bad_nx;
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = ov_q;
  assign bus.code_err  = ce_q;
  assign bus.disp_err  = de_q;
  assign bus.rd        = rd_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = ecnt_q;

endmodule

// File: tb/tb_decoder_10b8b.sv
// tb_decoder_10b8b: directed + random checks of decoder_10b8b
// against a table-driven encoder/decoder model.
module tb_decoder_10b8b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decoder_10b8b_if bus ();

  decoder_10b8b #(.LOCK_CNT(4), .UNLOCK_CNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // RD=0 column in abcdei / fghj order; RD=1 derived below.
  logic [5:0] b6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  logic [3:0] b4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  logic [5:0] t6 [2][32];
  logic [3:0] t4 [2][8];

  logic       m_rd, m_ov, m_ce, m_de, m_lock;
  logic [7:0] m_data;
  int         m_good, m_bad, m_cnt;
  logic       e_rd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_rd = 0; m_ov = 0; m_ce = 0; m_de = 0; m_lock = 0;
    m_data = 0; m_good = 0; m_bad = 0; m_cnt = 0; e_rd = 0;
  endtask

  function automatic void look6(input logic [5:0] c, input logic r,
                                output bit hit, output logic [4:0] v);
    hit = 0; v = 0;
    for (int i = 0; i < 32; i++)
      if (t6[r][i] == c) begin hit = 1; v = 5'(i); end
  endfunction

  function automatic void look4(input logic [3:0] c, input logic r,
                                output bit hit, output logic [2:0] v);
    hit = 0; v = 0;
    for (int i = 0; i < 8; i++)
      if (t4[r][i] == c) begin hit = 1; v = 3'(i); end
  endfunction

  function automatic logic [9:0] enc(input logic [7:0] b, input logic r);
    return {t6[r][b[4:0]], t4[r][b[7:5]]};
  endfunction

  function automatic logic rd_next(input logic [9:0] w, input logic r);
    int n;
    n = $countones(w);
    return (n > 5) ? 1'b1 : (n < 5) ? 1'b0 : r;
  endfunction

  task automatic model(input logic v, input logic [9:0] d, input logic clr);
    bit c6, o6, c4, o4, ce, de, err;
    logic [4:0] a6, x6;
    logic [2:0] a4, x4;
    err = 0;
    if (v) begin
      look6(d[9:4], m_rd, c6, a6);
      look6(d[9:4], ~m_rd, o6, x6);
      look4(d[3:0], m_rd, c4, a4);
      look4(d[3:0], ~m_rd, o4, x4);
      ce = (!c6 && !o6) || (!c4 && !o4);
      de = (!c6 && o6) || (!c4 && o4);
      err = ce || de;
      m_data = {c4 ? a4 : o4 ? x4 : 3'd0, c6 ? a6 : o6 ? x6 : 5'd0};
      m_ce = ce;
      m_de = de;
      m_rd = rd_next(d, de ? ~m_rd : m_rd);
      if (!m_lock) begin
        m_good = err ? 0 : m_good + 1;
        if (m_good == 4) begin m_lock = 1; m_good = 0; end
      end else begin
        m_bad = err ? m_bad + 1 : 0;
        if (m_bad == 4) begin m_lock = 0; m_bad = 0; end
      end
    end
    m_ov = v;
    if (clr) m_cnt = 0;
    else if (err && m_cnt < 65535) m_cnt++;
  endtask

  task automatic step(input logic v, input logic [9:0] d, input logic clr,
                      input string tag);
    bus.in_valid = v;
    bus.data_in  = d;
    bus.err_clr  = clr;
    @(posedge clk);
    #1;
    model(v, d, clr);
    chk(tag,
        {bus.data_out, bus.out_valid, bus.code_err, bus.disp_err,
         bus.rd, bus.locked, bus.err_count},
        {m_data, m_ov, m_ce, m_de, m_rd, m_lock, m_cnt[15:0]});
  endtask

  task automatic do_reset();
    rst = 0;
    bus.in_valid = 0;
    #1;
    mreset();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] w;
    int k, r;
    for (int i = 0; i < 32; i++) begin
      t6[0][i] = b6[i];
      t6[1][i] = ($countones(b6[i]) != 3 || i == 7) ? ~b6[i] : b6[i];
    end
    for (int i = 0; i < 8; i++) begin
      t4[0][i] = b4[i];
      t4[1][i] = ($countones(b4[i]) != 2 || i == 3) ? ~b4[i] : b4[i];
    end
    bus.in_valid = 0;
    bus.data_in  = 0;
    bus.err_clr  = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",
        {bus.data_out, bus.out_valid, bus.code_err, bus.disp_err,
         bus.rd, bus.locked, bus.err_count}, 32'd0);
    rst = 1;

    step(1, 10'h27B, 0, "d27b");
    chk("d27b_data", bus.data_out, 8'h00);
    chk("d27b_flags", {bus.code_err, bus.disp_err}, 2'b00);
    chk("d27b_rd", bus.rd, 1'b1);
    step(1, 10'h184, 0, "d184");
    chk("d184_data", bus.data_out, 8'h00);
    chk("d184_rd", bus.rd, 1'b0);

    do_reset();
    step(1, 10'h184, 0, "disp");
    chk("disp_flags", {bus.code_err, bus.disp_err}, 2'b01);
    chk("disp_rd", bus.rd, 1'b0);
    chk("disp_cnt", bus.err_count, 16'd1);

    do_reset();
    step(0, 10'h000, 0, "lb_first");
    k = 0;
    for (int n = 0; n < 1000; n++) begin
      if (n >= 10 && $urandom_range(0, 7) == 0) begin
        step(0, 10'($urandom), 0, "lb_idle");
      end else begin
        b = (n < 256) ? 8'(n) : 8'($urandom);
        w = enc(b, e_rd);
        e_rd = rd_next(w, e_rd);
        step(1, w, 0, "lb");
        k++;
        chk("lb_byte", bus.data_out, b);
        chk("lb_rd", bus.rd, e_rd);
        if (k == 3) chk("lb_lock3", bus.locked, 1'b0);
        if (k == 4) chk("lb_lock4", bus.locked, 1'b1);
      end
    end
    chk("lb_errs", bus.err_count, 16'd0);

    for (int i = 0; i < 3; i++) begin
      step(1, 10'h3FF, 0, "bad3");
      chk("bad3_code", bus.code_err, 1'b1);
      chk("bad3_lo", bus.data_out[4:0], 5'd0);
    end
    step(1, enc(8'($urandom), m_rd), 0, "clean");
    chk("clean_lock", bus.locked, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1, 10'h3FF, 0, "bad4");
      chk("bad4_lock", bus.locked, (i < 3) ? 1'b1 : 1'b0);
    end

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 3);
      if (r == 0) w = 10'($urandom);
      else if (r == 1) w = enc(8'($urandom), 1'($urandom));
      else w = enc(8'($urandom), m_rd);
      step($urandom_range(0, 9) != 0, w, $urandom_range(0, 19) == 0, "rand");
    end

    do_reset();
    for (int i = 0; i < 65534; i++) step(1, 10'h3FF, 0, "sat_fill");
    chk("sat_fffe", bus.err_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) step(1, 10'h3FF, 0, "sat_more");
    chk("sat_ffff", bus.err_count, 16'hFFFF);
    step(1, 10'h3FF, 1, "clr_err");
    chk("clr_zero", bus.err_count, 16'd0);

    step(1, enc(8'h5A, m_rd), 0, "pre_rst");
    step(1, 10'h3FF, 0, "pre_rst_bad");
    chk("pre_rst_rd", bus.rd, 1'b1);
    bus.in_valid = 1;
    bus.data_in  = enc(8'hC3, 1'b1);
    #3;
    rst = 0;
    #1;
    chk("async_rst",
        {bus.data_out, bus.out_valid, bus.code_err, bus.disp_err,
         bus.rd, bus.locked, bus.err_count}, 32'd0);
    mreset();
    @(posedge clk);
    #1;
    rst = 1;
    step(1, 10'h27B, 0, "post_rst");
    chk("post_rst_flags", {bus.code_err, bus.disp_err}, 2'b00);
    chk("post_rst_rd", bus.rd, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_10b8b.md
# decoder_10b8b

Receive-side counterpart of the team's 8b/10b line encoder. Takes one 10-bit code word per qualified cycle, tracks running disparity (RD) exactly as the encoder updates it, and returns the 8-bit data byte. Flags code and disparity violations, keeps a saturating error count, and runs a word-lock state machine. Sits behind the deserializer and word aligner, ahead of the byte sink.

## Interface
- LOCK_CNT, 4: consecutive clean words needed to go HUNT→LOCKED (1..15).
- UNLOCK_CNT, 4: consecutive errored words needed to go LOCKED→HUNT (1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  data_in is a code word this cycle.
- data_in  in  10  code word; [9:4] = 6b sub-block (from byte bits [4:0]), [3:0] = 4b sub-block (from byte bits [7:5]).
- err_clr  in  1  synchronous clear of err_count.
- data_out  out  8  decoded byte.
- out_valid  out  1  data_out/flags valid this cycle.
- code_err  out  1  a sub-block is in neither RD table.
- disp_err  out  1  a sub-block is only in the opposite-RD table.
- rd  out  1  running disparity after the last accepted word.
- locked  out  1  lock FSM is in LOCKED.
- err_count  out  16  saturating count of errored words.

## Operation
- Decode tables are the exact inverse of the encoder's two tables (RD=0 and RD=1), 6b→5b and 4b→3b. The union of both tables is unambiguous; each code maps to one value.
- Per sub-block: found in current-rd table → decode, no error. Found only in other-rd table → decode, disp_err. Not found → data bits 0, code_err.
- Errored word: code_err or disp_err.
- RD update, per accepted word with ones = popcount(data_in): ones>5 → rd=1; ones<5 → rd=0; ones==5 → rd = eff_rd, where eff_rd = ~rd if disp_err else rd. This always resynchronises RD, whatever the lock state.
- in_valid=0: out_valid=0. data_out, flags, rd, FSM and counters hold.
- Lock FSM:
  - HUNT: a clean word increments good_cnt. An errored word zeroes good_cnt. When good_cnt reaches LOCK_CNT → LOCKED, and good_cnt clears.
  - LOCKED: an errored word increments bad_cnt. A clean word zeroes bad_cnt. When bad_cnt reaches UNLOCK_CNT → HUNT, and bad_cnt clears.
- err_count: +1 per errored accepted word; saturates at 16'hFFFF. When err_clr and an error occur in the same cycle, the clear wins and that error is not counted.
- Reset values: data_out 0, out_valid 0, code_err 0, disp_err 0, rd 0, locked 0, err_count 0, FSM in HUNT, internal counters 0. rd=0 matches the encoder's reset RD.

## Timing
- Latency 1: a word sampled with in_valid at edge k appears on data_out/out_valid/flags after edge k; rd reflects it after the same edge.
- locked changes on the edge that accepts the qualifying word.
- The encoder drives 10'h000 during its first post-reset cycle. Upstream deasserts in_valid for that word; if it is accepted, it is a code error.
- Reset asserted mid-stream: all state returns to reset values asynchronously. The first word after reset release is decoded against rd=0.
- No backpressure; one word per cycle sustained.

## Structure
- Shared package (alongside the encoder): sub-block width constants, the FSM state enum (HUNT, LOCKED), and the 6b/4b code constants for both RD columns, so encoder and decoder share one source of truth.
- One sub-module, dec_subblock_lut: combinational lookup of (code, rd) → value, hit_cur, hit_other. Instantiated twice, once for 6b and once for 4b.
- Top level: popcount, RD register, lock FSM, counters, output registers.

## Test plan
- After reset, rd=0: 10'h27B → data_out 8'h00, no flags, rd=1. Then 10'h184 → 8'h00, rd=0.
- Exhaustive loopback: drive all 256 bytes for 1000 cycles through the encoder into the decoder, with in_valid masking the first cycle → bytes match with 1-cycle latency, rd tracks the encoder, zero flags, locked rises after the 4th word.
- rd=0, 10'h184 → data_out 8'h00, disp_err=1, code_err=0, rd=0, err_count=1.
- 10'h3FF → code_err=1, data_out[4:0]=0. While LOCKED, 4 consecutive 10'h3FF → locked falls on the 4th. A clean word interleaved before the 4th resets the count.
- err_count preloaded to 16'hFFFE by forcing errors, then 3 more errors → 16'hFFFF held. err_clr together with an error → 0.
- Reset pulsed mid-stream with in_valid high → all outputs 0 immediately. The next word is decoded with rd=0.
